// File: rtl/md_pkg.sv
// Shared encodings and types for the HI/LO multiply-divide issue controller.
// The optional same-cycle bypass is enabled by defining MD_BYPASS_EN.
package md_pkg;

    localparam logic [1:0] MD_MULTU = 2'd0;
    localparam logic [1:0] MD_DIVU  = 2'd1;
    localparam logic [1:0] MD_MULT  = 2'd2;
    localparam logic [1:0] MD_DIV   = 2'd3;

    localparam logic [1:0] MD_WE_NONE = 2'd0;
    localparam logic [1:0] MD_WE_HI   = 2'd1;
    localparam logic [1:0] MD_WE_LO   = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUED,
        BUSY
    } md_state_e;

    // Command half of a request; operands are appended by the user at its own width.
    typedef struct packed {
        logic [1:0] op;
        logic [1:0] we;
    } md_cmd_t;

endpackage

// File: rtl/md_req_fifo.sv
// Synchronous-write request FIFO with occupancy count; full/empty derive from the count.
// DEPTH must be a power of two so the pointers wrap naturally.
module md_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 68
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: occupancy is what makes an entry meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// In-order request buffer and issue sequencer in front of the HI/LO multiply-divide unit.
// Define MD_BYPASS_EN to issue a request straight to an idle unit in its acceptance cycle.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [1:0]               req_we,
    input  logic [DW-1:0]            req_a,
    input  logic [DW-1:0]            req_b,
    input  logic                     mf_req,
    output logic                     mf_stall,
    input  logic [4:0]               md_tim,
    output logic                     md_start,
    output logic [1:0]               md_op,
    output logic [1:0]               md_we,
    output logic [DW-1:0]            md_a,
    output logic [DW-1:0]            md_b,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    typedef struct packed {
        md_cmd_t       cmd;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } req_t;

    req_t      req_in;
    req_t      head;
    req_t      src;
    md_state_e state;
    md_state_e state_nxt;
    logic      full;
    logic      empty;
    logic      push;
    logic      pop;
    logic      bypass;
    logic      issue;

    assign req_in    = '{cmd: '{op: req_op, we: req_we}, a: req_a, b: req_b};
    assign req_ready = !full;

`ifdef MD_BYPASS_EN
    assign bypass = req_valid && empty && (state == IDLE) && (md_tim == '0);
`else
    assign bypass = 1'b0;
`endif

    // A bypassed request goes to the unit instead of the FIFO.
    assign push  = req_valid && req_ready && !bypass;
    assign issue = (state == IDLE) && (!empty || bypass);
    assign pop   = issue && !bypass;
    assign src   = bypass ? req_in : head;

    md_req_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(req_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (req_in),
        .rdata   (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        md_start  = 1'b0;
        md_we     = MD_WE_NONE;
        md_op     = MD_MULTU;
        md_a      = '0;
        md_b      = '0;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt = ISSUED;
                    md_start  = (src.cmd.we == MD_WE_NONE);
                    md_we     = src.cmd.we;
                    md_op     = src.cmd.op;
                    md_a      = src.a;
                    md_b      = src.b;
                end
            end
            // The unit loads its counter on the issue edge; mthi/mtlo never load one.
            ISSUED:  state_nxt = (md_tim != '0) ? BUSY : IDLE;
            BUSY:    if (md_tim == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (count != '0) || (state != IDLE) || (md_tim != '0);
    assign mf_stall = mf_req && busy;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl: a simple latency model of the HI/LO unit plus a
// reference of queue occupancy and unit availability checked every cycle.
module tb_md_issue_ctrl;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = '0;
    logic [1:0]    req_we = '0;
    logic [DW-1:0] req_a = '0;
    logic [DW-1:0] req_b = '0;
    logic          mf_req = 1'b0;
    logic          mf_stall;
    logic [4:0]    md_tim = '0;
    logic          md_start;
    logic [1:0]    md_op;
    logic [1:0]    md_we;
    logic [DW-1:0] md_a;
    logic [DW-1:0] md_b;
    logic          busy;
    logic [2:0]    count;

    logic [67:0] exp_q[$];
    int          issue_cyc[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    int          ref_pending = 0;
    bit          issued_prev = 0;
    logic [4:0]  tim_prev = '0;

    md_issue_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_we    (req_we),
        .req_a     (req_a),
        .req_b     (req_b),
        .mf_req    (mf_req),
        .mf_stall  (mf_stall),
        .md_tim    (md_tim),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_we     (md_we),
        .md_a      (md_a),
        .md_b      (md_b),
        .busy      (busy),
        .count     (count)
    );

    // ---------------- clock / unit model ----------------
    always #5 clk = ~clk;

    function automatic logic [4:0] unit_latency(input logic [1:0] op);
        return op[0] ? 5'd10 : 5'd5;  // odd encodings are divides
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)      md_tim <= '0;
        else if (md_start) md_tim <= unit_latency(md_op);
        else if (md_tim != 0) md_tim <= md_tim - 5'd1;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // ---------------- scoreboard monitor ----------------
    always begin : monitor
        logic [67:0] front;
        bit          acc, byp, iss_exp, idle_exp, busy_exp, iss_act;
        int          cnt_exp;
        @(negedge clk);
        #1;
        cyc++;
        if (!reset_n) begin
            exp_q.delete();
            ref_pending = 0;
            issued_prev = 0;
            tim_prev    = '0;
        end else begin
            cnt_exp  = ref_pending;
            idle_exp = !issued_prev && (tim_prev == 0);
`ifdef MD_BYPASS_EN
            byp = req_valid && idle_exp && (md_tim == 0) && (cnt_exp == 0);
`else
            byp = 0;
`endif
            acc      = req_valid && (cnt_exp < DEPTH);
            iss_exp  = idle_exp && ((cnt_exp != 0) || byp);
            busy_exp = (cnt_exp != 0) || !idle_exp || (md_tim != 0);
            iss_act  = md_start || (md_we != 2'd0);

            check("count", 80'(count), 80'(cnt_exp));
            check("req_ready", 80'(req_ready), 80'(cnt_exp < DEPTH));
            check("busy", 80'(busy), 80'(busy_exp));
            check("mf_stall", 80'(mf_stall), 80'(mf_req && busy_exp));
            check("issue_present", 80'(iss_act), 80'(iss_exp));
            if (iss_exp) begin
                if (exp_q.size() == 0) begin
                    check("issue_without_entry", 80'(1), 80'(0));
                end else begin
                    front = exp_q.pop_front();
                    check("issue_data", {11'd0, md_start, md_op, md_we, md_a, md_b},
                          {11'd0, (front[65:64] == 2'd0), front});
                    issue_cyc.push_back(cyc);
                end
            end else begin
                check("quiet_outputs", {11'd0, md_start, md_op, md_we, md_a, md_b}, 80'd0);
            end
            ref_pending = ref_pending + ((acc && !byp) ? 1 : 0) - ((iss_exp && !byp) ? 1 : 0);
            issued_prev = iss_exp;
            tim_prev    = md_tim;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [1:0] op, input logic [1:0] we,
                        input logic [31:0] a, input logic [31:0] b);
        bit done = 0;
        req_valid = 1'b1;
        req_op = op;
        req_we = we;
        req_a  = a;
        req_b  = b;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back({op, we, a, b});
                done = 1;
            end
        end
        if (!done) check("push_timeout", 80'(0), 80'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        bit done = 0;
        req_valid = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1;
        end
        if (!done) check("drain_timeout", 80'(0), 80'(1));
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n0;
        bit done;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_ready", 80'(req_ready), 80'(1));
        check("reset_busy", 80'(busy), 80'(0));
        check("reset_count", 80'(count), 80'(0));
        @(posedge clk);
        #1;

        // single mult; issue the cycle after acceptance, busy lingers one cycle past md_tim==0
        push(2'd2, 2'd0, 32'hFFFF_FFFF, 32'd2);
        req_valid = 1'b0;
`ifndef MD_BYPASS_EN
        @(negedge clk);
        check("mult_issue_start", 80'(md_start), 80'(1));
        check("mult_issue_op", 80'(md_op), 80'(2));
        repeat (6) @(negedge clk);
        check("mult_tim_zero_busy", 80'(busy), 80'(1));
        @(negedge clk);
        check("mult_busy_clear", 80'(busy), 80'(0));
`endif
        wait_drain();

        // divu then mtlo back to back
        n0 = issue_cyc.size();
        push(2'd1, 2'd0, 32'd100, 32'd7);
        push(2'd0, 2'd2, 32'h1234, 32'd0);
        wait_drain();
        check("divu_mtlo_issues", 80'(issue_cyc.size() - n0), 80'(2));
        if (issue_cyc.size() >= n0 + 2)
            check("mtlo_gap_ge_10", 80'(issue_cyc[n0+1] - issue_cyc[n0] >= 10), 80'(1));

        // fill: unit busy with a div, then five more requests
        push(2'd3, 2'd0, 32'd50, 32'd5);
        for (int i = 0; i < 4; i++) push(2'(i), 2'd0, 32'(i + 1), 32'(i + 10));
        @(negedge clk);
        check("full_ready_low", 80'(req_ready), 80'(0));
        check("full_count", 80'(count), 80'(DEPTH));
        push(2'd0, 2'd1, 32'hDEAD_BEEF, 32'd0);
        wait_drain();

        // mf_req with two queued behind a busy unit
        push(2'd2, 2'd0, 32'd3, 32'd4);
        push(2'd0, 2'd1, 32'hAAAA, 32'd0);
        push(2'd0, 2'd0, 32'd9, 32'd9);
        req_valid = 1'b0;
        mf_req = 1'b1;
        @(negedge clk);
        check("mf_stall_start", 80'(mf_stall), 80'(1));
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!mf_stall) done = 1;
        end
        check("mf_release_seen", 80'(done), 80'(1));
        check("mf_release_count", 80'(count), 80'(0));
        check("mf_release_tim", 80'(md_tim), 80'(0));
        @(posedge clk);
        #1;
        mf_req = 1'b0;
        wait_drain();

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            logic [1:0] we;
            we = 2'($urandom_range(0, 2));
            mf_req = ($urandom_range(0, 3) == 0);
            push(2'($urandom_range(0, 3)), we, $urandom, $urandom);
            idle($urandom_range(0, 3));
        end
        mf_req = 1'b0;
        wait_drain();

        // signed div from an idle unit: same-cycle issue only with the bypass
        req_valid = 1'b1;
        req_op = 2'd3;
        req_we = 2'd0;
        req_a  = 32'hFFFF_FFF8;
        req_b  = 32'd3;
        @(negedge clk);
        check("div_accept_ready", 80'(req_ready), 80'(1));
        exp_q.push_back({2'd3, 2'd0, 32'hFFFF_FFF8, 32'd3});
`ifdef MD_BYPASS_EN
        check("bypass_start", 80'(md_start), 80'(1));
        check("bypass_op", 80'(md_op), 80'(3));
        check("bypass_count", 80'(count), 80'(0));
`else
        check("nobypass_no_start", 80'(md_start), 80'(0));
`endif
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
`ifndef MD_BYPASS_EN
        check("nobypass_start_next", 80'(md_start), 80'(1));
        check("nobypass_op_next", 80'(md_op), 80'(3));
`endif
        wait_drain();

        // reset with three entries queued behind a busy div
        push(2'd1, 2'd0, 32'd1000, 32'd3);
        for (int i = 0; i < 3; i++) push(2'd2, 2'd0, 32'(i), 32'(i));
        req_valid = 1'b0;
        #1;
        check("pre_reset_count", 80'(count), 80'(3));
        reset_n = 1'b0;
        #1;
        check("async_reset_count", 80'(count), 80'(0));
        check("async_reset_start", 80'(md_start), 80'(0));
        check("async_reset_busy", 80'(busy), 80'(0));
        check("async_reset_ready", 80'(req_ready), 80'(1));
        @(negedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        push(2'd0, 2'd0, 32'd7, 32'd6);
        wait_drain();
        idle(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
